btn_scan_ctrl: RTL and testbench
================================

Name: btn_scan_ctrl

Overview:
- Multi-button front-end controller that produces a 1 ms sampling tick from the system clock.
- On each tick it time-shares one debounce/long-press evaluation datapath across N_BTN buttons, in round-robin order.
- Outputs are a debounced state vector and a single valid/ready event port (press, release, long-press) for the downstream UI/control logic.

Parameters:
- N_BTN, 4, number of buttons; range 1..16.
- CLK_DIV, 100000, system clocks per sample tick (1 ms at 100 MHz); must be >= N_BTN+2.
- HIST, 8, consecutive equal samples needed to change the debounced state; range 2..16.
- LONG_MS, 1000, ticks of continuous debounced press before a long event; range 1..65535.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- button, input, N_BTN, raw asynchronous button levels; 1 = pressed.
- stable, output, N_BTN, debounced button state.
- evt_valid, output, 1, event available.
- evt_ready, input, 1, consumer accepts the event.
- evt_id, output, 4, index of the button that caused the event.
- evt_type, output, 2, event type: 01 press, 10 release, 11 long; 00 is never emitted.
- evt_ovf, output, 1, sticky flag: an event was dropped.
- ovf_clr, input, 1, clears evt_ovf.

Behaviour:
- Reset (async, rst_n=0):
  - Tick counter=0, FSM=IDLE, scan idx=0.
  - All history registers=0, all hold counters=0.
  - stable=0, evt_valid=0, evt_id=0, evt_type=00, evt_ovf=0.
  - A reset asserted mid-scan abandons the scan; no partial event survives.
- Synchronizer: button passes through a 2-FF synchronizer per bit (sync). Only sync is sampled.
- Tick generation:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tick=1 for one cycle when counter==CLK_DIV-1.
- FSM, states IDLE and SCAN:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: process button idx in this cycle, then idx+1. After idx==N_BTN-1, return to IDLE and set idx=0.
  - If tick is at cycle T, button k is processed in cycle T+1+k.
  - A tick during SCAN cannot occur, because CLK_DIV >= N_BTN+2.
- Per-button processing (button i, one cycle):
  - h' = {hist[i][HIST-2:0], sync[i]}; hist[i] <= h'.
  - If h' is all ones and stable[i]=0: stable[i] <= 1, hold[i] <= 0, emit press.
  - If h' is all zeros and stable[i]=1: stable[i] <= 0, hold[i] <= 0, emit release.
  - Otherwise, if stable[i]=1 and hold[i] < LONG_MS: hold[i] <= hold[i]+1. If hold[i]+1 == LONG_MS, emit long.
  - hold[i] is 16 bits and saturates at LONG_MS, so there is exactly one long event per press.
  - At most one event is generated per cycle.
- Latency:
  - Debounced change and event generation happen in cycle T+1+i of the HIST-th consecutive equal sample.
  - evt_valid rises in cycle T+2+i.
  - Long event is emitted LONG_MS ticks after the press tick.
- Event port:
  - Transfer occurs when evt_valid & evt_ready.
  - While evt_valid=1 and not accepted, evt_id and evt_type are held constant.
  - New event while the port is empty, or while the held event is accepted in the same cycle: load the new event, evt_valid stays or becomes 1.
  - New event while evt_valid=1 & !evt_ready: drop the new event, set evt_ovf=1, keep the held event unchanged.
  - Acceptance with no new event: evt_valid <= 0.
- Overflow flag:
  - ovf_clr clears evt_ovf next cycle.
  - If a drop coincides with ovf_clr, evt_ovf stays 1 (set wins).
- stable changes regardless of event-port backpressure; debounced state is never lost.

Test Plan:
Bench settings for all scenarios: N_BTN=4, CLK_DIV=10, HIST=4, LONG_MS=20.
- Reset state: hold rst_n=0, toggle button → all outputs 0. Release reset → first tick at cycle 9 after release; no events with buttons idle.
- Clean press and release on button 2, evt_ready=1: stable[2] rises on the 4th tick after the synchronized edge. One event {id=2,type=01} is presented. Release gives {id=2,type=10} after 4 more ticks.
- Bounce rejection: button 1 toggles 1,0,1,1,0,1 across consecutive ticks → stable[1] stays 0 and no event occurs. Then 4 consecutive ones → exactly one press.
- Long press: hold button 0 for 30 ticks → press, then {id=0,type=11} exactly 20 ticks after the press tick, then no further events. Release → type 10.
- Backpressure/overflow: evt_ready=0, press buttons 0 and 3 on the same tick → evt shows {0,01} held, {3,01} dropped, evt_ovf=1, stable=1001. Pulse ovf_clr → evt_ovf=0. Then evt_ready=1 → {0,01} accepted, evt_valid=0.
- Async reset mid-scan: assert rst_n=0 in cycle T+2 of a scan with a pending event → everything returns to reset values immediately, and no event is output after release.

Source files
------------

// File: rtl/btn_scan_ctrl.sv
// Multi-button debounce and long-press controller. A 1 ms tick starts a
// round-robin scan that shares one evaluation datapath across all buttons.
module btn_scan_ctrl #(
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned HIST    = 8,
  parameter int unsigned LONG_MS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_id,
  output logic [1:0]       evt_type,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned HOLD_W = 16;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  logic [N_BTN-1:0]  sync_meta;
  logic [N_BTN-1:0]  sync;
  logic [CNT_W-1:0]  cnt;
  logic              tick_c;
  state_e            state;
  state_e            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              proc_c;

  logic [HIST-1:0]   hist [N_BTN];
  logic [HOLD_W-1:0] hold [N_BTN];

  logic [HIST-1:0]   h_new_c;
  logic [HOLD_W-1:0] hold_cur_c;
  logic              stb_cur_c;
  logic              set_c;
  logic              clr_c;
  logic              inc_c;
  logic              new_evt_c;
  evt_type_e         new_type_c;
  logic              drop_c;

  // Two-flop synchronizer on the raw button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= button;
      sync      <= sync_meta;
    end
  end

  // Sample tick divider
  assign tick_c = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Scan FSM: one button evaluated per SCAN cycle
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    proc_c    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_c) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        proc_c = 1'b1;
        if (idx == IDX_W'(N_BTN - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Shared evaluation datapath for the button selected by idx
  always_comb begin
    h_new_c    = {hist[idx][HIST-2:0], sync[idx]};
    hold_cur_c = hold[idx];
    stb_cur_c  = stable[idx];
    set_c      = 1'b0;
    clr_c      = 1'b0;
    inc_c      = 1'b0;
    new_evt_c  = 1'b0;
    new_type_c = EVT_NONE;
    if (proc_c) begin
      if ((&h_new_c) && !stb_cur_c) begin
        set_c      = 1'b1;
        new_evt_c  = 1'b1;
        new_type_c = EVT_PRESS;
      end else if (!(|h_new_c) && stb_cur_c) begin
        clr_c      = 1'b1;
        new_evt_c  = 1'b1;
        new_type_c = EVT_RELEASE;
      end else if (stb_cur_c && (hold_cur_c < HOLD_W'(LONG_MS))) begin
        inc_c = 1'b1;
        // Counter saturates at LONG_MS, so this fires once per press
        if ((hold_cur_c + HOLD_W'(1)) == HOLD_W'(LONG_MS)) begin
          new_evt_c  = 1'b1;
          new_type_c = EVT_LONG;
        end
      end
    end
  end

  // Per-button history, debounced state and hold counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        hist[i] <= '0;
        hold[i] <= '0;
      end
      stable <= '0;
    end else if (proc_c) begin
      hist[idx] <= h_new_c;
      if (set_c || clr_c) begin
        stable[idx] <= set_c;
        hold[idx]   <= '0;
      end else if (inc_c) begin
        hold[idx] <= hold_cur_c + HOLD_W'(1);
      end
    end
  end

  assign drop_c = new_evt_c && evt_valid && !evt_ready;

  // Single-entry event port; a new event is dropped only under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_NONE;
      evt_ovf   <= 1'b0;
    end else begin
      if (new_evt_c) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_id    <= 4'(idx);
          evt_type  <= new_type_c;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (drop_c) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Directed bench for btn_scan_ctrl: per-sample vector table plus hand-written
// sequences for overflow handling and reset during a scan.
module tb_btn_scan_ctrl;

  localparam int unsigned N_BTN   = 4;
  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned HIST    = 4;
  localparam int unsigned LONG_MS = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic [3:0] stable;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_ovf;
  logic       ovf_clr;

  int cyc;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] id;
    logic [1:0] ty;
    int         cyc;
  } ev_t;
  ev_t ev_q[$];

  // One vector = one sample period: drive btn/rdy, wait one tick period, check
  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic [3:0] s;
    int         n;
    logic [3:0] id;
    logic [1:0] ty;
    logic       v;
    logic       o;
  } vec_t;
  vec_t tbl[$];

  btn_scan_ctrl #(
    .N_BTN  (N_BTN),
    .CLK_DIV(CLK_DIV),
    .HIST   (HIST),
    .LONG_MS(LONG_MS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button   (button),
    .stable   (stable),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_type (evt_type),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Log every accepted event, sampled between edges
  always @(negedge clk) begin : mon
    ev_t e;
    #2;
    if (rst_n === 1'b1 && evt_valid && evt_ready) begin
      e.id  = evt_id;
      e.ty  = evt_type;
      e.cyc = cyc;
      ev_q.push_back(e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic r, input logic [3:0] s, input int n,
                     input logic [3:0] id, input logic [1:0] ty, input logic v, input logic o);
    vec_t x;
    x.btn = b; x.rdy = r; x.s = s; x.n = n; x.id = id; x.ty = ty; x.v = v; x.o = o;
    tbl.push_back(x);
  endtask

  task automatic add_rep(input int cnt, input logic [3:0] b, input logic r, input logic [3:0] s);
    for (int i = 0; i < cnt; i++) add(b, r, s, 0, 4'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // Land on a negedge in the middle of the tick period, clear of the scan
  task automatic goto_phase();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cyc % 10) != 5 && k < 40);
    chk("phase_align", k, cyc % 10, 5);
  endtask

  task automatic apply(input int lo, input int hi);
    int n0;
    for (int i = lo; i < hi; i++) begin
      n0 = ev_q.size();
      button    = tbl[i].btn;
      evt_ready = tbl[i].rdy;
      repeat (10) @(negedge clk);
      chk("stable", i, stable, tbl[i].s);
      chk("evt_count", i, ev_q.size() - n0, tbl[i].n);
      if (tbl[i].n > 0) begin
        chk("evt_id", i, ev_q[$].id, tbl[i].id);
        chk("evt_type", i, ev_q[$].ty, tbl[i].ty);
      end
      chk("evt_valid", i, evt_valid, tbl[i].v);
      chk("evt_ovf", i, evt_ovf, tbl[i].o);
    end
  endtask

  initial begin
    int seg1;
    int seg2;
    int seg3;
    int n_long;
    int n0;

    rst_n     = 1'b1;
    button    = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Idle after reset
    add_rep(2, 4'b0000, 1'b1, 4'b0000);
    // Clean press/release on button 2
    add_rep(3, 4'b0100, 1'b1, 4'b0000);
    add(4'b0100, 1'b1, 4'b0100, 1, 4'd2, 2'b01, 1'b0, 1'b0);
    add_rep(3, 4'b0000, 1'b1, 4'b0100);
    add(4'b0000, 1'b1, 4'b0000, 1, 4'd2, 2'b10, 1'b0, 1'b0);
    // Bounce on button 1, then a clean run of ones
    add_rep(1, 4'b0010, 1'b1, 4'b0000);
    add_rep(1, 4'b0000, 1'b1, 4'b0000);
    add_rep(2, 4'b0010, 1'b1, 4'b0000);
    add_rep(1, 4'b0000, 1'b1, 4'b0000);
    add_rep(3, 4'b0010, 1'b1, 4'b0000);
    add(4'b0010, 1'b1, 4'b0010, 1, 4'd1, 2'b01, 1'b0, 1'b0);
    add_rep(1, 4'b0010, 1'b1, 4'b0010);
    add_rep(3, 4'b0000, 1'b1, 4'b0010);
    add(4'b0000, 1'b1, 4'b0000, 1, 4'd1, 2'b10, 1'b0, 1'b0);
    // Long press on button 0: 30 samples held
    add_rep(3, 4'b0001, 1'b1, 4'b0000);
    add(4'b0001, 1'b1, 4'b0001, 1, 4'd0, 2'b01, 1'b0, 1'b0);
    add_rep(19, 4'b0001, 1'b1, 4'b0001);
    add(4'b0001, 1'b1, 4'b0001, 1, 4'd0, 2'b11, 1'b0, 1'b0);
    add_rep(6, 4'b0001, 1'b1, 4'b0001);
    add_rep(3, 4'b0000, 1'b1, 4'b0001);
    add(4'b0000, 1'b1, 4'b0000, 1, 4'd0, 2'b10, 1'b0, 1'b0);
    // Simultaneous press on buttons 0 and 3 under backpressure
    add_rep(3, 4'b1001, 1'b0, 4'b0000);
    add(4'b1001, 1'b0, 4'b1001, 0, 4'd0, 2'd0, 1'b1, 1'b1);
    seg1 = tbl.size();
    // Release both with the port open
    add_rep(3, 4'b0000, 1'b1, 4'b1001);
    add(4'b0000, 1'b1, 4'b0000, 2, 4'd3, 2'b10, 1'b0, 1'b0);
    // Prime button 0 for the reset-during-scan sequence
    add_rep(3, 4'b0001, 1'b0, 4'b0000);
    seg2 = tbl.size();
    seg3 = seg2;

    // Reset holds every output at zero while buttons toggle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      button = 4'(i * 5 + 1);
      chk("rst_stable", i, stable, 4'b0000);
      chk("rst_valid", i, evt_valid, 1'b0);
      chk("rst_id", i, evt_id, 4'd0);
      chk("rst_type", i, evt_type, 2'b00);
      chk("rst_ovf", i, evt_ovf, 1'b0);
    end
    @(negedge clk);
    button = '0;
    rst_n  = 1'b1;
    goto_phase();

    apply(0, seg1);

    // Latency: button 2 press seen in cycle T+2+2 of its scan (T = 9 mod 10)
    chk("press_phase", 0, (ev_q.size() > 0) ? (ev_q[0].cyc % 10) : 99, 3);
    // Exactly one long event, LONG_MS ticks after its press
    n_long = 0;
    for (int j = 1; j < ev_q.size(); j++) begin
      if (ev_q[j].ty == 2'b11) begin
        n_long++;
        chk("long_delay", j, ev_q[j].cyc - ev_q[j-1].cyc, LONG_MS * CLK_DIV);
        chk("long_after_press", j, ev_q[j-1].ty, 2'b01);
      end
    end
    chk("long_count", 0, n_long, 1);

    // Held event survives, dropped one sets the sticky flag; clear then accept
    chk("ovf_hold_id", 0, evt_id, 4'd0);
    chk("ovf_hold_type", 0, evt_type, 2'b01);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 0, evt_ovf, 1'b0);
    chk("ovf_still_valid", 0, evt_valid, 1'b1);
    chk("ovf_still_id", 0, evt_id, 4'd0);
    n0 = ev_q.size();
    evt_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", 0, evt_valid, 1'b0);
    chk("accept_count", 0, ev_q.size() - n0, 1);
    chk("accept_id", 0, (ev_q.size() > n0) ? ev_q[$].id : 4'hf, 4'd0);
    chk("accept_type", 0, (ev_q.size() > n0) ? ev_q[$].ty : 2'b00, 2'b01);
    goto_phase();

    apply(seg1, seg3);

    // Fourth sample of button 0: press event pending at T+2, then reset
    button    = 4'b0001;
    evt_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("pend_valid", 0, evt_valid, 1'b1);
    chk("pend_type", 0, evt_type, 2'b01);
    chk("pend_stable", 0, stable, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stable", 0, stable, 4'b0000);
    chk("mid_rst_valid", 0, evt_valid, 1'b0);
    chk("mid_rst_id", 0, evt_id, 4'd0);
    chk("mid_rst_type", 0, evt_type, 2'b00);
    chk("mid_rst_ovf", 0, evt_ovf, 1'b0);
    button = '0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    n0 = ev_q.size();
    repeat (60) @(negedge clk);
    chk("post_rst_events", 0, ev_q.size() - n0, 0);
    chk("post_rst_valid", 0, evt_valid, 1'b0);
    chk("post_rst_stable", 0, stable, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
